// File: rtl/audio_pll_lock_ctrl_if.sv
// Control/status bundle between system CSR logic, the audio PLL and its lock sequencer.
// master = system/PLL side, slave = the sequencer.
interface audio_pll_lock_ctrl_if;
  logic       enable;
  logic       restart;
  logic       pll_locked;
  logic       pll_rst;
  logic       clk_ready;
  logic       fail;
  logic [7:0] lock_loss_count;
  logic [2:0] state;

  modport master (
    output enable, restart, pll_locked,
    input  pll_rst, clk_ready, fail, lock_loss_count, state
  );
  modport slave (
    input  enable, restart, pll_locked,
    output pll_rst, clk_ready, fail, lock_loss_count, state
  );
endinterface

// File: rtl/audio_pll_lock_ctrl.sv
// Audio PLL reset/lock sequencer: pulses pll_rst, debounces lock, qualifies clk_ready,
// retries on timeout and re-locks after lock loss. Single refclk domain.
module audio_pll_lock_ctrl #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 1000000,
  parameter int MAX_RETRIES         = 3
) (
  input logic                  refclk,
  input logic                  rst_n,
  audio_pll_lock_ctrl_if.slave bus
);
  localparam logic [2:0] DISABLED  = 3'd0;
  localparam logic [2:0] RESET_PLL = 3'd1;
  localparam logic [2:0] WAIT_LOCK = 3'd2;
  localparam logic [2:0] STABLE    = 3'd3;
  localparam logic [2:0] RUN       = 3'd4;
  localparam logic [2:0] FAILED    = 3'd5;

  localparam int MAX_AB = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ? RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_C  = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
  localparam int TW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;
  localparam int RW     = $clog2(MAX_RETRIES + 1);

  localparam logic [TW-1:0] RST_LAST    = TW'(RST_PULSE_CYCLES - 1);
  localparam logic [TW-1:0] STABLE_LAST = TW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRIES);

  logic [2:0]    st;
  logic [TW-1:0] timer;
  logic [RW-1:0] retry_cnt;
  logic [RW-1:0] retry_inc;
  logic [7:0]    loss_cnt;
  logic [1:0]    sync;
  logic          locked_s;

  // pll_locked is asynchronous; only the second flop's output is ever looked at
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b00;
    else        sync <= {sync[0], bus.pll_locked};
  end
  assign locked_s  = sync[1];
  assign retry_inc = retry_cnt + RW'(1);

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= RESET_PLL;
      timer     <= '0;
      retry_cnt <= '0;
      loss_cnt  <= '0;
    end else if (!bus.enable) begin
      st        <= DISABLED;
      timer     <= '0;
      retry_cnt <= '0;
    end else if (bus.restart && st != DISABLED) begin
      st        <= RESET_PLL;
      timer     <= '0;
      retry_cnt <= '0;
    end else begin
      case (st)
        DISABLED: begin
          st    <= RESET_PLL;
          timer <= '0;
        end
        RESET_PLL: begin
          if (timer == RST_LAST) begin
            st    <= WAIT_LOCK;
            timer <= '0;
          end else timer <= timer + TW'(1);
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            st    <= STABLE;
            timer <= '0;
          end else if (timer == TMO_LAST) begin
            retry_cnt <= retry_inc;
            timer     <= '0;
            st        <= (retry_inc == RETRY_LIMIT) ? FAILED : RESET_PLL;
          end else timer <= timer + TW'(1);
        end
        STABLE: begin
          if (!locked_s) begin
            // a glitch restarts the full timeout window but is not a retry
            st    <= WAIT_LOCK;
            timer <= '0;
          end else if (timer == STABLE_LAST) begin
            st        <= RUN;
            timer     <= '0;
            retry_cnt <= '0;
          end else timer <= timer + TW'(1);
        end
        RUN: begin
          if (!locked_s) begin
            st    <= RESET_PLL;
            timer <= '0;
            if (loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 8'd1;
          end
        end
        FAILED: begin
          timer <= '0;
        end
        default: begin
          st    <= RESET_PLL;
          timer <= '0;
        end
      endcase
    end
  end

  assign bus.pll_rst         = (st == DISABLED) || (st == RESET_PLL) || (st == FAILED);
  assign bus.clk_ready       = (st == RUN);
  assign bus.fail            = (st == FAILED);
  assign bus.lock_loss_count = loss_cnt;
  assign bus.state           = st;
endmodule

// File: tb/tb_audio_pll_lock_ctrl.sv
// Bench for audio_pll_lock_ctrl: table vectors, directed corner sequences and random
// stimulus compared every cycle against a countdown-based reference model.
module tb_audio_pll_lock_ctrl;
  localparam int RSTP = 4;
  localparam int STBL = 8;
  localparam int TMO  = 32;
  localparam int MAXR = 2;

  logic refclk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  audio_pll_lock_ctrl_if bus ();

  audio_pll_lock_ctrl #(
    .RST_PULSE_CYCLES   (RSTP),
    .LOCK_STABLE_CYCLES (STBL),
    .LOCK_TIMEOUT_CYCLES(TMO),
    .MAX_RETRIES        (MAXR)
  ) dut (
    .refclk(refclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  // reference model: phase number plus cycles remaining in that phase
  int ms, left, retries, losses;
  bit s1, s2;

  function automatic void model_reset();
    ms = 1; left = RSTP; retries = 0; losses = 0; s1 = 0; s2 = 0;
  endfunction

  function automatic void mstep(input bit en, input bit rs, input bit lk);
    bit ls;
    ls = s2;
    if (!en) begin
      ms = 0; retries = 0;
    end else if (rs && ms != 0) begin
      ms = 1; left = RSTP; retries = 0;
    end else begin
      case (ms)
        0: begin ms = 1; left = RSTP; end
        1: begin left--; if (left == 0) begin ms = 2; left = TMO; end end
        2: if (ls) begin ms = 3; left = STBL; end
           else begin
             left--;
             if (left == 0) begin
               retries++;
               if (retries == MAXR) ms = 5;
               else begin ms = 1; left = RSTP; end
             end
           end
        3: if (!ls) begin ms = 2; left = TMO; end
           else begin left--; if (left == 0) begin ms = 4; retries = 0; end end
        4: if (!ls) begin ms = 1; left = RSTP; if (losses < 255) losses++; end
        default: ;
      endcase
    end
    s2 = s1;
    s1 = lk;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("m_state", int'(bus.state), ms);
    chk("m_pll_rst", int'(bus.pll_rst), int'(ms == 0 || ms == 1 || ms == 5));
    chk("m_clk_ready", int'(bus.clk_ready), int'(ms == 4));
    chk("m_fail", int'(bus.fail), int'(ms == 5));
    chk("m_loss_cnt", int'(bus.lock_loss_count), losses);
  endtask

  task automatic tick();
    mstep(bus.enable, bus.restart, bus.pll_locked);
    @(posedge refclk);
    #1;
    cmp_model();
  endtask

  task automatic chk_out(input string nm, input int st, input int prst, input int rdy, input int fl);
    chk({nm, "_state"}, int'(bus.state), st);
    chk({nm, "_pll_rst"}, int'(bus.pll_rst), prst);
    chk({nm, "_clk_ready"}, int'(bus.clk_ready), rdy);
    chk({nm, "_fail"}, int'(bus.fail), fl);
  endtask

  typedef struct {
    bit en; bit rs; bit lk; int n;
    int st; int prst; int rdy; int fl;
  } vec_t;

  vec_t tbl[19];
  bit   lk;

  initial begin
    // bring-up to RUN, then disable, then timeout/retry path to FAIL and restart
    tbl[0]  = '{1, 0, 0,  3, 1, 1, 0, 0};
    tbl[1]  = '{1, 0, 0,  1, 2, 0, 0, 0};
    tbl[2]  = '{1, 0, 0,  9, 2, 0, 0, 0};
    tbl[3]  = '{1, 0, 1,  2, 2, 0, 0, 0};
    tbl[4]  = '{1, 0, 1,  1, 3, 0, 0, 0};
    tbl[5]  = '{1, 0, 1,  7, 3, 0, 0, 0};
    tbl[6]  = '{1, 0, 1,  1, 4, 0, 1, 0};
    tbl[7]  = '{0, 0, 0,  1, 0, 1, 0, 0};
    tbl[8]  = '{1, 0, 0,  1, 1, 1, 0, 0};
    tbl[9]  = '{1, 0, 0,  4, 2, 0, 0, 0};
    tbl[10] = '{1, 0, 0, 31, 2, 0, 0, 0};
    tbl[11] = '{1, 0, 0,  1, 1, 1, 0, 0};
    tbl[12] = '{1, 0, 0,  3, 1, 1, 0, 0};
    tbl[13] = '{1, 0, 0,  1, 2, 0, 0, 0};
    tbl[14] = '{1, 0, 0, 31, 2, 0, 0, 0};
    tbl[15] = '{1, 0, 0,  1, 5, 1, 0, 1};
    tbl[16] = '{1, 0, 0, 50, 5, 1, 0, 1};
    tbl[17] = '{1, 1, 0,  1, 1, 1, 0, 0};
    tbl[18] = '{1, 0, 0,  4, 2, 0, 0, 0};

    rst_n = 1'b0;
    bus.enable = 1'b1; bus.restart = 1'b0; bus.pll_locked = 1'b0;
    @(posedge refclk);
    #1;
    chk_out("reset", 1, 1, 0, 0);
    chk("reset_loss_cnt", int'(bus.lock_loss_count), 0);
    rst_n = 1'b1;
    model_reset();

    for (int i = 0; i < 19; i++) begin
      bus.enable = tbl[i].en; bus.restart = tbl[i].rs; bus.pll_locked = tbl[i].lk;
      for (int k = 0; k < tbl[i].n; k++) begin
        tick();
        bus.restart = 1'b0;
      end
      chk_out($sformatf("vec%0d", i), tbl[i].st, tbl[i].prst, tbl[i].rdy, tbl[i].fl);
    end

    // one-cycle lock glitch at stable count 5 falls back to WAIT_LOCK
    bus.pll_locked = 1'b1;
    repeat (3) tick();
    chk_out("glitch_enter", 3, 0, 0, 0);
    repeat (5) tick();
    bus.pll_locked = 1'b0; tick();
    bus.pll_locked = 1'b1; tick();
    chk_out("glitch_hold", 3, 0, 0, 0);
    tick();
    chk_out("glitch_drop", 2, 0, 0, 0);
    repeat (8) tick();
    chk_out("glitch_relock", 3, 0, 0, 0);
    tick();
    chk_out("glitch_run", 4, 0, 1, 0);

    // restart coinciding with synced lock loss: no loss counted
    bus.pll_locked = 1'b0;
    repeat (2) tick();
    bus.restart = 1'b1; tick(); bus.restart = 1'b0;
    chk_out("restart_loss", 1, 1, 0, 0);
    chk("restart_loss_cnt", int'(bus.lock_loss_count), 0);
    bus.enable = 1'b0; tick();
    chk_out("disable", 0, 1, 0, 0);
    bus.enable = 1'b1; bus.pll_locked = 1'b1;
    for (int k = 0; k < 40 && !bus.clk_ready; k++) tick();
    chk("reenable_ready", int'(bus.clk_ready), 1);

    // repeated lock loss in RUN: saturating counter
    for (int i = 0; i < 260; i++) begin
      bus.pll_locked = 1'b0;
      repeat (3) tick();
      chk("loss_ready", int'(bus.clk_ready), 0);
      chk("loss_state", int'(bus.state), 1);
      chk("loss_cnt", int'(bus.lock_loss_count), (i + 1 > 255) ? 255 : i + 1);
      bus.pll_locked = 1'b1;
      for (int k = 0; k < 40 && !bus.clk_ready; k++) tick();
      chk("loss_relock", int'(bus.clk_ready), 1);
    end

    // asynchronous reset in the middle of WAIT_LOCK
    bus.pll_locked = 1'b0;
    for (int k = 0; k < 20 && bus.state != 3'd2; k++) tick();
    chk("pre_async_state", int'(bus.state), 2);
    #2 rst_n = 1'b0;
    #1;
    chk_out("async_rst", 1, 1, 0, 0);
    chk("async_rst_loss_cnt", int'(bus.lock_loss_count), 0);
    #3 rst_n = 1'b1;
    model_reset();

    // random stimulus against the model
    lk = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      bus.enable  = ($urandom_range(199) != 0);
      bus.restart = ($urandom_range(199) < 2);
      if ($urandom_range(99) < 5) lk = ~lk;
      bus.pll_locked = lk;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/audio_pll_lock_ctrl.md
Name: audio_pll_lock_ctrl

Overview:
Sequences the audio PLL that generates the 18.432 MHz codec clock from the 50 MHz reference. It drives the PLL reset and debounces the PLL locked flag. It publishes a clean clock-ready qualifier, and re-locks automatically after lock loss. Runs entirely in the refclk domain; it sits between the system reset/CSR logic and the audio PLL instance.

Parameters:
RST_PULSE_CYCLES, 16, refclk cycles pll_rst is held high per reset attempt (>=1)
LOCK_STABLE_CYCLES, 1024, consecutive synced-locked cycles required before clk_ready (>=1)
LOCK_TIMEOUT_CYCLES, 1000000, refclk cycles allowed in WAIT_LOCK before a retry (20 ms at 50 MHz)
MAX_RETRIES, 3, consecutive timeouts tolerated before FAIL (>=1)

Ports:
refclk  in  1  50 MHz reference clock, free-running
rst_n  in  1  asynchronous active-low reset
enable  in  1  level; 0 holds the PLL in reset
restart  in  1  single-cycle pulse; forces a fresh reset/lock sequence
pll_locked  in  1  PLL locked flag, asynchronous to refclk
pll_rst  out  1  active-high PLL reset
clk_ready  out  1  PLL output is stable and usable
fail  out  1  retries exhausted
lock_loss_count  out  8  saturating count of lock losses while in RUN
state  out  3  current FSM state, for the CSR/debug interface

Behaviour:
- One clock and one reset: refclk, with rst_n asynchronous and active-low. Assertion of rst_n is asynchronous; deassertion is sampled on refclk.
- Reset values: state=RESET_PLL(1), pll_rst=1, clk_ready=0, fail=0, lock_loss_count=0, all timers and retry_cnt=0, synchronizer flops=0.
- pll_locked passes through a 2-flop synchronizer (locked_s). Raw pll_locked is never used directly.
- State encodings: DISABLED=0, RESET_PLL=1, WAIT_LOCK=2, STABLE=3, RUN=4, FAIL=5.
- Outputs are decoded from the registered state:
  - pll_rst=1 in DISABLED, RESET_PLL and FAIL.
  - clk_ready=1 only in RUN.
  - fail=1 only in FAIL.
- Transition priority each cycle: enable=0 first, then restart, then the per-state rules below.
- enable=0 from any state: go to DISABLED, clear the timer and retry_cnt. DISABLED with enable=1: go to RESET_PLL, timer=0.
- restart=1 in any state except DISABLED: go to RESET_PLL, timer=0, retry_cnt=0. This also clears fail. In RUN, a simultaneous lock loss does NOT increment lock_loss_count.
- RESET_PLL: timer counts up. At timer==RST_PULSE_CYCLES-1, go to WAIT_LOCK with timer=0. pll_rst is therefore high for exactly RST_PULSE_CYCLES cycles per attempt.
- WAIT_LOCK: timer counts up.
  - locked_s=1: go to STABLE, timer=0.
  - Otherwise, at timer==LOCK_TIMEOUT_CYCLES-1: increment retry_cnt. If the new retry_cnt==MAX_RETRIES, go to FAIL; else go to RESET_PLL, timer=0.
- STABLE: timer counts while locked_s=1.
  - locked_s=0: go to WAIT_LOCK, timer=0. The timeout window restarts; retry_cnt is unchanged.
  - At timer==LOCK_STABLE_CYCLES-1 with locked_s=1: go to RUN, retry_cnt=0.
- RUN: locked_s=0 goes to RESET_PLL with timer=0. On that same edge, lock_loss_count increments, saturating at 255. clk_ready falls the cycle after locked_s falls.
- FAIL: pll_rst held high. Exits only via restart, enable=0 or rst_n.
- Latency: pll_locked rising at edge k, then held, gives locked_s=1 at k+2, STABLE at k+3, and clk_ready=1 at k+3+LOCK_STABLE_CYCLES.
- Timer width is clog2 of the largest of the three cycle parameters. It never wraps, because every state clears it on exit.
- lock_loss_count is cleared only by rst_n.

Test Plan:
All scenarios use RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2.
1. Release rst_n with enable=1; raise pll_locked 10 cycles after pll_rst falls -> pll_rst high exactly 4 cycles; clk_ready rises 11 cycles after pll_locked rises; state=4.
2. In STABLE, drop pll_locked for 1 cycle at stable-count 5 -> state returns to 2, no clk_ready pulse; clk_ready only after 8 further consecutive locked cycles.
3. pll_locked held 0 -> two pll_rst pulses of 4 cycles each, separated by 32-cycle waits; then state=5, fail=1, pll_rst=1. A later restart pulse -> fail=0 and a new 4-cycle sequence.
4. In RUN, drop pll_locked -> clk_ready=0 within 3 cycles, lock_loss_count 0->1, new 4-cycle pll_rst pulse. Repeat 260 times -> count saturates at 255.
5. In RUN, assert restart in the same cycle locked_s falls -> state=1, lock_loss_count unchanged. Then deassert enable -> state=0, pll_rst=1, clk_ready=0.
6. Assert rst_n low mid-WAIT_LOCK, asynchronously between edges -> outputs take reset values immediately, without waiting for a clock edge.
